mvb_pipe_multi: RTL and testbench
=================================

Name: mvb_pipe_multi

Overview:
- Parametrised multi-stage MVB register pipe; successor to the single-stage MVB pipe.
- Inserts STAGES registered stages between an MVB source and sink.
- Every stage is a 2-entry skid buffer, so DST_RDY is registered at each stage boundary and full throughput is kept.
- Adds optional dropping of empty words and a live occupancy count; used for timing closure on long MVB routes across the chip.

Parameters:
- ITEMS, 4, MVB items per word.
- ITEM_WIDTH, 8, bits per item.
- STAGES, 2, number of skid stages (>=1).
- USE_DST_RDY, true, false = TX_DST_RDY is ignored and treated as 1.
- DROP_EMPTY, false, true = words with SRC_RDY=1 and all VLD=0 are discarded at the input.
- DEVICE, "AGILEX", target device (passed through, no behavioural effect).

Ports:
- CLK  in  1  clock.
- RESET  in  1  asynchronous, active-low reset.
- RX_DATA  in  ITEMS*ITEM_WIDTH  input items.
- RX_VLD  in  ITEMS  per-item valid.
- RX_SRC_RDY  in  1  input word valid.
- RX_DST_RDY  out  1  input ready.
- TX_DATA  out  ITEMS*ITEM_WIDTH  output items.
- TX_VLD  out  ITEMS  per-item valid.
- TX_SRC_RDY  out  1  output word valid.
- TX_DST_RDY  in  1  output ready.
- OCCUPANCY  out  clog2(2*STAGES+1)  words currently held across all stages.

Behaviour:
- Reset:
  - RESET=0 asynchronously clears all stage state.
  - Reset values: TX_SRC_RDY=0, TX_VLD=0, TX_DATA=0, OCCUPANCY=0, RX_DST_RDY=1.
  - No transfer is recorded while RESET=0.
  - Reset mid-operation discards all held words; no partial word appears after release.
- Transfer rule: a transfer occurs on a rising CLK edge when SRC_RDY=1 and DST_RDY=1. Data and VLD are sampled only at transfers.
- Stage FSM (mvb_skid_stage), per stage, states EMPTY, ONE, FULL:
  - EMPTY: out_src_rdy=0, in_dst_rdy=1. Input transfer -> ONE (word goes to the main register).
  - ONE: out_src_rdy=1, in_dst_rdy=1.
    - Input and output transfer together -> ONE, main register replaced.
    - Input transfer only -> FULL, word goes to the skid register.
    - Output transfer only -> EMPTY.
  - FULL: in_dst_rdy=0. Output transfer -> ONE, skid register moves to main.
  - in_dst_rdy is the registered inverse of FULL; it never depends combinationally on out_dst_rdy.
- Chaining: stage k output feeds stage k+1 input. Stage 0 input is RX; stage STAGES-1 output is TX.
- Latency: exactly STAGES cycles from RX transfer to TX_SRC_RDY=1 when there is no backpressure. Throughput is 1 word/cycle sustained.
- Ordering: words leave in arrival order, with VLD and DATA bit-exact, no reordering inside a word.
- Backpressure: after TX_DST_RDY drops, RX_DST_RDY falls within STAGES cycles. Up to 2*STAGES words are then absorbed; none is lost or duplicated.
- USE_DST_RDY=false:
  - TX_DST_RDY is internally forced to 1, so stages never reach FULL and RX_DST_RDY stays 1.
  - OCCUPANCY <= STAGES.
- DROP_EMPTY=true:
  - A word with RX_SRC_RDY=1 and RX_VLD=0 is accepted (handshake completes when RX_DST_RDY=1) but not stored.
  - OCCUPANCY does not change for it.
- OCCUPANCY:
  - Registered sum of per-stage counts (EMPTY=0, ONE=1, FULL=2).
  - Updates the cycle after the corresponding transfers.
  - Simultaneous input and output transfers leave it unchanged.
- TX_VLD:
  - Forced to 0 whenever TX_SRC_RDY=0.
  - TX_DATA is don't-care when TX_SRC_RDY=0, except it reads 0 after reset.

Decomposition:
- Shared package mvb_pipe_pkg holds:
  - typedef stage_state_t {EMPTY, ONE, FULL};
  - function occ_width(stages) returning clog2(2*stages+1).
- Sub-module mvb_skid_stage: one 2-entry stage with in/out MVB handshake and a 2-bit count output.
- Top level holds only the generate chain, DROP_EMPTY gating and the occupancy adder.

Test Plan:
- Flow-through: STAGES=3, TX_DST_RDY=1, 10 back-to-back words with DATA=0x00..0x09 and VLD=0xF -> TX word i appears at cycle i+3, bit-exact, TX_SRC_RDY continuous for 10 cycles.
- Full stall: STAGES=2, TX_DST_RDY=0, RX pushes continuously -> exactly 4 words accepted, RX_DST_RDY=0 from then on, OCCUPANCY=4. Releasing TX_DST_RDY then emits the 4 words in order, and RX_DST_RDY returns to 1.
- Random backpressure: 1000 words, TX_DST_RDY random at 50% -> scoreboard finds zero loss, duplication or reorder, and OCCUPANCY never exceeds 4.
- DROP_EMPTY=true: input stream VLD=0xF,0x0,0x3,0x0 -> TX shows only 0xF then 0x3, and OCCUPANCY peaks at 2.
- Reset mid-stall: OCCUPANCY=4, then RESET=0 for 1 cycle -> TX_SRC_RDY=0 and OCCUPANCY=0 immediately, and only post-reset words appear on TX.
- USE_DST_RDY=false: TX_DST_RDY held 0 -> TX still streams at 1 word/cycle and RX_DST_RDY stays 1.

Source files
------------

// File: rtl/mvb_pipe_multi_pkg.sv
// Shared types and helpers for the multi-stage MVB register pipe.
package mvb_pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

  // Width needed to count every word the pipe can hold (0 .. 2*stages).
  function automatic int occ_width(input int stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/mvb_pipe_multi_stage.sv
// One 2-entry skid stage: a main register that drives the output and a skid
// register that catches the word arriving in the cycle the sink stalls.
// Input ready is registered, so no combinational path crosses the stage.
module mvb_skid_stage
  import mvb_pipe_pkg::*;
#(
  parameter int ITEMS      = 4,
  parameter int ITEM_WIDTH = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [ITEMS*ITEM_WIDTH-1:0] in_data_i,
  input  logic [ITEMS-1:0]            in_vld_i,
  input  logic                        in_src_rdy_i,
  output logic                        in_dst_rdy_o,
  output logic [ITEMS*ITEM_WIDTH-1:0] out_data_o,
  output logic [ITEMS-1:0]            out_vld_o,
  output logic                        out_src_rdy_o,
  input  logic                        out_dst_rdy_i,
  output logic [1:0]                  count_o
);

  localparam int DW = ITEMS * ITEM_WIDTH;

  stage_state_t    state_q, state_d;
  logic            inRdy_q, outRdy_q;
  logic [DW-1:0]   mainData_q, skidData_q;
  logic [ITEMS-1:0] mainVld_q, skidVld_q;
  logic            inXfer, outXfer;

  assign inXfer  = in_src_rdy_i & inRdy_q;
  assign outXfer = outRdy_q & out_dst_rdy_i;

  // Next occupancy state; count_o is the count held once this edge completes.
  always_comb begin
    state_d = state_q;
    count_o = 2'd0;
    case (state_q)
      EMPTY: if (inXfer) state_d = ONE;
      ONE: begin
        if (inXfer && !outXfer)      state_d = FULL;
        else if (!inXfer && outXfer) state_d = EMPTY;
      end
      FULL: if (outXfer) state_d = ONE;
      default: state_d = EMPTY;
    endcase
    case (state_d)
      ONE:     count_o = 2'd1;
      FULL:    count_o = 2'd2;
      default: count_o = 2'd0;
    endcase
  end

  // State register with its handshake outputs registered alongside it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= EMPTY;
      inRdy_q  <= 1'b1;
      outRdy_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      inRdy_q  <= (state_d != FULL);
      outRdy_q <= (state_d != EMPTY);
    end
  end

  // Word storage: main feeds the output, skid absorbs the stalled arrival.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mainData_q <= '0;
      mainVld_q  <= '0;
      skidData_q <= '0;
      skidVld_q  <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (inXfer) begin
            mainData_q <= in_data_i;
            mainVld_q  <= in_vld_i;
          end
        end
        ONE: begin
          if (inXfer && outXfer) begin
            mainData_q <= in_data_i;
            mainVld_q  <= in_vld_i;
          end else if (inXfer) begin
            skidData_q <= in_data_i;
            skidVld_q  <= in_vld_i;
          end
        end
        FULL: begin
          if (outXfer) begin
            mainData_q <= skidData_q;
            mainVld_q  <= skidVld_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_dst_rdy_o  = inRdy_q;
  assign out_src_rdy_o = outRdy_q;
  assign out_data_o    = mainData_q;
  assign out_vld_o     = outRdy_q ? mainVld_q : '0;

endmodule

// File: rtl/mvb_pipe_multi.sv
// Multi-stage MVB register pipe: a chain of skid stages for long routes, with
// optional dropping of empty words and a registered occupancy count.
module mvb_pipe_multi
  import mvb_pipe_pkg::*;
#(
  parameter int    ITEMS       = 4,
  parameter int    ITEM_WIDTH  = 8,
  parameter int    STAGES      = 2,
  parameter bit    USE_DST_RDY = 1'b1,
  parameter bit    DROP_EMPTY  = 1'b0,
  parameter string DEVICE      = "AGILEX"
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic [ITEMS*ITEM_WIDTH-1:0]      RX_DATA,
  input  logic [ITEMS-1:0]                 RX_VLD,
  input  logic                             RX_SRC_RDY,
  output logic                             RX_DST_RDY,
  output logic [ITEMS*ITEM_WIDTH-1:0]      TX_DATA,
  output logic [ITEMS-1:0]                 TX_VLD,
  output logic                             TX_SRC_RDY,
  input  logic                             TX_DST_RDY,
  output logic [occ_width(STAGES)-1:0]     OCCUPANCY
);

  localparam int DW = ITEMS * ITEM_WIDTH;
  localparam int OW = occ_width(STAGES);

  logic [DW-1:0]    chData [STAGES+1];
  logic [ITEMS-1:0] chVld  [STAGES+1];
  logic             chSrc  [STAGES+1];
  logic             chDst  [STAGES+1];
  logic [1:0]       stCount [STAGES];
  logic [OW-1:0]    occ_d, occ_q;
  logic             rxKeep;

  // DEVICE only selects the target family; the pipe behaves identically.
  if (DEVICE == "") begin : g_device_unset
  end

  // An empty word still completes its handshake but never enters stage 0.
  assign rxKeep     = DROP_EMPTY ? (|RX_VLD) : 1'b1;
  assign chData[0]  = RX_DATA;
  assign chVld[0]   = RX_VLD;
  assign chSrc[0]   = RX_SRC_RDY & rxKeep;
  assign RX_DST_RDY = chDst[0];

  assign chDst[STAGES] = USE_DST_RDY ? TX_DST_RDY : 1'b1;
  assign TX_DATA       = chData[STAGES];
  assign TX_VLD        = chVld[STAGES];
  assign TX_SRC_RDY    = chSrc[STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    mvb_skid_stage #(
      .ITEMS      (ITEMS),
      .ITEM_WIDTH (ITEM_WIDTH)
    ) u_stage (
      .clk_i         (CLK),
      .rst_ni        (RESET),
      .in_data_i     (chData[k]),
      .in_vld_i      (chVld[k]),
      .in_src_rdy_i  (chSrc[k]),
      .in_dst_rdy_o  (chDst[k]),
      .out_data_o    (chData[k+1]),
      .out_vld_o     (chVld[k+1]),
      .out_src_rdy_o (chSrc[k+1]),
      .out_dst_rdy_i (chDst[k+1]),
      .count_o       (stCount[k])
    );
  end

  // Sum of the per-stage counts each stage will hold after this edge.
  always_comb begin
    occ_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      occ_d = occ_d + OW'(stCount[k]);
    end
  end

  // Occupancy register, aligned with the stage state registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) occ_q <= '0;
    else        occ_q <= occ_d;
  end

  assign OCCUPANCY = occ_q;

endmodule

// File: tb/tb_mvb_pipe_multi.sv
// Self-checking bench for mvb_pipe_multi: four instances cover the default
// pipe, a 3-stage flow-through, empty-word dropping and ignored TX ready.
module tb_mvb_pipe_multi;

  typedef logic [35:0] word_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   compared;
  int   mismatched;

  logic [31:0] aRxData, aTxData, bRxData, bTxData, cRxData, cTxData, dRxData, dTxData;
  logic [3:0]  aRxVld, aTxVld, bRxVld, bTxVld, cRxVld, cTxVld, dRxVld, dTxVld;
  logic        aRxSrc, aRxDst, aTxSrc, aTxDst;
  logic        bRxSrc, bRxDst, bTxSrc, bTxDst;
  logic        cRxSrc, cRxDst, cTxSrc, cTxDst;
  logic        dRxSrc, dRxDst, dTxSrc, dTxDst;
  logic [2:0]  aOcc, cOcc, dOcc;
  logic [2:0]  bOcc;

  word_t qA[$], qB[$], qC[$], qD[$];
  int    cycQB[$], cycQD[$];
  int    aOut, bOut, cOut, dOut;
  int    bIn, dIn, bStart, dStart;
  int    cPeak;
  bit    chkOccA;

  mvb_pipe_multi #(.STAGES(2)) dutA (
    .CLK(clk), .RESET(rst_n),
    .RX_DATA(aRxData), .RX_VLD(aRxVld), .RX_SRC_RDY(aRxSrc), .RX_DST_RDY(aRxDst),
    .TX_DATA(aTxData), .TX_VLD(aTxVld), .TX_SRC_RDY(aTxSrc), .TX_DST_RDY(aTxDst),
    .OCCUPANCY(aOcc)
  );

  mvb_pipe_multi #(.STAGES(3)) dutB (
    .CLK(clk), .RESET(rst_n),
    .RX_DATA(bRxData), .RX_VLD(bRxVld), .RX_SRC_RDY(bRxSrc), .RX_DST_RDY(bRxDst),
    .TX_DATA(bTxData), .TX_VLD(bTxVld), .TX_SRC_RDY(bTxSrc), .TX_DST_RDY(bTxDst),
    .OCCUPANCY(bOcc)
  );

  mvb_pipe_multi #(.STAGES(2), .DROP_EMPTY(1'b1)) dutC (
    .CLK(clk), .RESET(rst_n),
    .RX_DATA(cRxData), .RX_VLD(cRxVld), .RX_SRC_RDY(cRxSrc), .RX_DST_RDY(cRxDst),
    .TX_DATA(cTxData), .TX_VLD(cTxVld), .TX_SRC_RDY(cTxSrc), .TX_DST_RDY(cTxDst),
    .OCCUPANCY(cOcc)
  );

  mvb_pipe_multi #(.STAGES(2), .USE_DST_RDY(1'b0)) dutD (
    .CLK(clk), .RESET(rst_n),
    .RX_DATA(dRxData), .RX_VLD(dRxVld), .RX_SRC_RDY(dRxSrc), .RX_DST_RDY(dRxDst),
    .TX_DATA(dTxData), .TX_VLD(dTxVld), .TX_SRC_RDY(dTxSrc), .TX_DST_RDY(dTxDst),
    .OCCUPANCY(dOcc)
  );

  // Free-running clock and a cycle counter used for latency checks.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts rising edges so monitors can timestamp output words.
  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle on instance A and reports whether RX accepted the word.
  task automatic applyStimulus(input logic src, input logic [31:0] data, input logic [3:0] vld,
                               input logic txRdy, output logic accepted);
    aRxSrc  = src;
    aRxData = data;
    aRxVld  = vld;
    aTxDst  = txRdy;
    @(negedge clk);
    accepted = src && aRxDst;
    @(posedge clk);
    #1;
  endtask

  // Instance A scoreboard: push accepted RX words, pop and compare on TX.
  always @(negedge clk) begin
    if (rst_n) begin
      if (aRxSrc && aRxDst) qA.push_back({aRxVld, aRxData});
      if (aTxSrc && aTxDst) begin
        if (qA.size() == 0) checkOutput("A_unexpected_word", 64'(1), 64'(0));
        else checkOutput("A_word", 64'({aTxVld, aTxData}), 64'(qA.pop_front()));
        aOut++;
      end
      if (!aTxSrc) checkOutput("A_vld_gated", 64'(aTxVld), 64'(0));
      if (chkOccA) checkOutput("A_occ_le4", 64'(aOcc <= 3'd4), 64'(1));
    end
  end

  // Instance B scoreboard: also checks the cycle each word leaves.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bRxSrc && bRxDst) begin
        qB.push_back({bRxVld, bRxData});
        cycQB.push_back(bStart + bIn + 3);
        bIn++;
      end
      if (bTxSrc && bTxDst) begin
        if (qB.size() == 0) checkOutput("B_unexpected_word", 64'(1), 64'(0));
        else begin
          checkOutput("B_word", 64'({bTxVld, bTxData}), 64'(qB.pop_front()));
          checkOutput("B_latency_cycle", 64'(cyc), 64'(cycQB.pop_front()));
        end
        bOut++;
      end
    end
  end

  // Instance C scoreboard: only words with some valid item are expected.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cRxSrc && cRxDst && (|cRxVld)) qC.push_back({cRxVld, cRxData});
      if (cTxSrc && cTxDst) begin
        if (qC.size() == 0) checkOutput("C_unexpected_word", 64'(1), 64'(0));
        else checkOutput("C_word", 64'({cTxVld, cTxData}), 64'(qC.pop_front()));
        cOut++;
      end
      if (int'(cOcc) > cPeak) cPeak = int'(cOcc);
    end
  end

  // Instance D scoreboard: TX ready is ignored, so every valid TX word leaves.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dRxSrc && dRxDst) begin
        qD.push_back({dRxVld, dRxData});
        cycQD.push_back(dStart + dIn + 2);
        dIn++;
      end
      if (dTxSrc) begin
        if (qD.size() == 0) checkOutput("D_unexpected_word", 64'(1), 64'(0));
        else begin
          checkOutput("D_word", 64'({dTxVld, dTxData}), 64'(qD.pop_front()));
          checkOutput("D_stream_cycle", 64'(cyc), 64'(cycQD.pop_front()));
        end
        dOut++;
      end
      checkOutput("D_occ_le2", 64'(dOcc <= 3'd2), 64'(1));
    end
  end

  // Directed sequence: reset, flow-through, stall, random, reset mid-stall,
  // empty-word dropping and ignored TX ready.
  initial begin
    logic ok;
    int   acc, sent, guard, outBefore;
    logic [3:0] cVldTab [4];

    compared = 0; mismatched = 0;
    aOut = 0; bOut = 0; cOut = 0; dOut = 0; bIn = 0; dIn = 0;
    bStart = 0; dStart = 0; cPeak = 0; chkOccA = 0;
    cVldTab[0] = 4'hF; cVldTab[1] = 4'h0; cVldTab[2] = 4'h3; cVldTab[3] = 4'h0;
    aRxSrc = 0; aRxData = '0; aRxVld = '0; aTxDst = 1;
    bRxSrc = 0; bRxData = '0; bRxVld = '0; bTxDst = 1;
    cRxSrc = 0; cRxData = '0; cRxVld = '0; cTxDst = 1;
    dRxSrc = 0; dRxData = '0; dRxVld = '0; dTxDst = 1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_tx_src", 64'(aTxSrc), 64'(0));
    checkOutput("rst_tx_vld", 64'(aTxVld), 64'(0));
    checkOutput("rst_tx_data", 64'(aTxData), 64'(0));
    checkOutput("rst_occ", 64'(aOcc), 64'(0));
    checkOutput("rst_rx_dst", 64'(aRxDst), 64'(1));
    checkOutput("rst_b_occ", 64'(bOcc), 64'(0));
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] flow-through, 3 stages");
    bStart = cyc;
    for (int i = 0; i < 10; i++) begin
      bRxSrc = 1; bRxData = 32'(i); bRxVld = 4'hF;
      @(posedge clk);
      #1;
    end
    bRxSrc = 0;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("B_out_count", 64'(bOut), 64'(10));

    $display("[TB] full stall, 2 stages");
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 32'hA000_0000 + 32'(acc), 4'hF, 1'b0, ok);
      if (ok) acc++;
    end
    checkOutput("stall_accepted", 64'(acc), 64'(4));
    checkOutput("stall_rx_dst", 64'(aRxDst), 64'(0));
    checkOutput("stall_occ", 64'(aOcc), 64'(4));
    outBefore = aOut;
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, '0, 1'b1, ok);
    checkOutput("release_count", 64'(aOut - outBefore), 64'(4));
    checkOutput("release_rx_dst", 64'(aRxDst), 64'(1));
    checkOutput("release_occ", 64'(aOcc), 64'(0));

    $display("[TB] random backpressure");
    chkOccA = 1;
    sent = 0; guard = 0; outBefore = aOut;
    while (sent < 1000 && guard < 20000) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), $urandom, 4'($urandom),
                    1'($urandom_range(0, 1)), ok);
      if (ok) sent++;
      guard++;
    end
    checkOutput("rand_sent", 64'(sent), 64'(1000));
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, '0, 1'b1, ok);
    checkOutput("rand_out_count", 64'(aOut - outBefore), 64'(1000));
    checkOutput("rand_queue_empty", 64'(qA.size()), 64'(0));
    chkOccA = 0;

    $display("[TB] reset mid-stall");
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 32'hEE00_0000 + 32'(i), 4'hF, 1'b0, ok);
    aRxSrc = 0;
    checkOutput("prereset_occ", 64'(aOcc), 64'(4));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_tx_src", 64'(aTxSrc), 64'(0));
    checkOutput("midrst_occ", 64'(aOcc), 64'(0));
    checkOutput("midrst_rx_dst", 64'(aRxDst), 64'(1));
    qA.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    outBefore = aOut;
    applyStimulus(1'b1, 32'h0000_00B0, 4'h5, 1'b1, ok);
    applyStimulus(1'b1, 32'h0000_00B1, 4'hA, 1'b1, ok);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, '0, 1'b1, ok);
    checkOutput("postrst_out_count", 64'(aOut - outBefore), 64'(2));
    checkOutput("postrst_queue_empty", 64'(qA.size()), 64'(0));

    $display("[TB] drop empty words");
    cPeak = 0;
    cTxDst = 0;
    for (int i = 0; i < 4; i++) begin
      cRxSrc = 1; cRxData = 32'h0000_00C0 + 32'(i); cRxVld = cVldTab[i];
      @(negedge clk);
      checkOutput("C_rx_dst", 64'(cRxDst), 64'(1));
      @(posedge clk);
      #1;
    end
    cRxSrc = 0;
    checkOutput("C_occ_held", 64'(cOcc), 64'(2));
    cTxDst = 1;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("C_out_count", 64'(cOut), 64'(2));
    checkOutput("C_occ_peak", 64'(cPeak), 64'(2));

    $display("[TB] TX ready ignored");
    dTxDst = 0;
    dStart = cyc;
    for (int i = 0; i < 8; i++) begin
      dRxSrc = 1; dRxData = 32'h0000_00D0 + 32'(i); dRxVld = 4'(i + 1);
      @(negedge clk);
      checkOutput("D_rx_dst", 64'(dRxDst), 64'(1));
      @(posedge clk);
      #1;
    end
    dRxSrc = 0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("D_out_count", 64'(dOut), 64'(8));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
